// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
//   Shared definitions for the gcd_seq engine:
//     gcd_state_e : FSM state encoding (IDLE/EVEN/ODD/DONE)
//     clog2()     : ceiling log2, used for the shared-power-of-two count width
// ---------------------------------------------------------------------------
package gcd_pkg;

    typedef enum logic [1:0] {
        GCD_IDLE = 2'd0,
        GCD_EVEN = 2'd1,
        GCD_ODD  = 2'd2,
        GCD_DONE = 2'd3
    } gcd_state_e;

    // Smallest r with 2**r >= v (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// ---------------------------------------------------------------------------
// gcd_stein_step
//   Combinational single step of the binary (Stein) GCD algorithm.
//   Ports:
//     even_phase_i : 1 = strip common factors of two, 0 = odd-reduction phase
//     a_i, b_i     : current operands (W bits)
//     k_i          : common power of two removed so far (KW bits)
//     a_o, b_o, k_o: operand/count values after this step
//     to_odd_o     : even phase finished (at least one operand is odd)
//     done_o       : a == b with both odd, result ready
//     res_o        : a << k, the GCD when done_o is high
// ---------------------------------------------------------------------------
module gcd_stein_step #(
    parameter int W  = 8,
    parameter int KW = 4
) (
    input  logic          even_phase_i,
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    input  logic [KW-1:0] k_i,
    output logic [W-1:0]  a_o,
    output logic [W-1:0]  b_o,
    output logic [KW-1:0] k_o,
    output logic          to_odd_o,
    output logic          done_o,
    output logic [W-1:0]  res_o
);

    always_comb begin
        a_o      = a_i;
        b_o      = b_i;
        k_o      = k_i;
        to_odd_o = 1'b0;
        done_o   = 1'b0;
        // Truncation to W bits is exact: the gcd never exceeds max(A,B).
        res_o    = a_i << k_i;

        if (even_phase_i) begin
            if (!a_i[0] && !b_i[0]) begin
                a_o = a_i >> 1;
                b_o = b_i >> 1;
                k_o = k_i + KW'(1);
            end else begin
                to_odd_o = 1'b1;
            end
        end else begin
            // One action per cycle; the compare guards the subtraction.
            if (!a_i[0])            a_o    = a_i >> 1;
            else if (!b_i[0])       b_o    = b_i >> 1;
            else if (a_i == b_i)    done_o = 1'b1;
            else if (a_i > b_i)     a_o    = a_i - b_i;
            else                    b_o    = b_i - a_i;
        end
    end

endmodule

// File: rtl/gcd_seq.sv
// ---------------------------------------------------------------------------
// gcd_seq
//   Multi-cycle binary GCD engine with valid/ready handshakes, one operation
//   in flight. Optional cycle counter enabled by defining GCD_CYCLES_EN.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     in_valid / in_ready  : operand handshake (in_ready = engine idle)
//     A, B                 : W-bit unsigned operands, sampled on transfer
//     out_valid / out_ready: result handshake, GCD held while out_valid
//     GCD                  : W-bit result
//     CYCLES               : CW-bit EVEN/ODD cycle count (GCD_CYCLES_EN only)
// ---------------------------------------------------------------------------
module gcd_seq
    import gcd_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  GCD
`ifdef GCD_CYCLES_EN
    ,
    output logic [CW-1:0] CYCLES
`endif
);

    localparam int KW = clog2(W + 1);

    // The counter must be able to hold the worst-case latency of 4*W+2.
    if (CW < clog2(4 * W + 3)) begin : g_cw_too_small
        $error("gcd_seq: CW too small for 4*W+2");
    end

    gcd_state_e    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [KW-1:0] k_q, k_d;

    logic [W-1:0]  step_a, step_b, step_res;
    logic [KW-1:0] step_k;
    logic          step_to_odd, step_done;

    gcd_stein_step #(.W(W), .KW(KW)) u_step (
        .even_phase_i (state_q == GCD_EVEN),
        .a_i          (a_q),
        .b_i          (b_q),
        .k_i          (k_q),
        .a_o          (step_a),
        .b_o          (step_b),
        .k_o          (step_k),
        .to_odd_o     (step_to_odd),
        .done_o       (step_done),
        .res_o        (step_res)
    );

    assign in_ready  = (state_q == GCD_IDLE);
    assign out_valid = (state_q == GCD_DONE);
    assign GCD       = gcd_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        gcd_d   = gcd_q;
        unique case (state_q)
            GCD_IDLE: begin
                if (in_valid) begin
                    a_d = A;
                    b_d = B;
                    k_d = '0;
                    // gcd(x,0) = x and gcd(0,0) = 0 both fall out of A|B.
                    if (A == '0 || B == '0) begin
                        gcd_d   = A | B;
                        state_d = GCD_DONE;
                    end else begin
                        state_d = GCD_EVEN;
                    end
                end
            end
            GCD_EVEN: begin
                a_d = step_a;
                b_d = step_b;
                k_d = step_k;
                if (step_to_odd) state_d = GCD_ODD;
            end
            GCD_ODD: begin
                a_d = step_a;
                b_d = step_b;
                if (step_done) begin
                    gcd_d   = step_res;
                    state_d = GCD_DONE;
                end
            end
            GCD_DONE: begin
                if (out_ready) state_d = GCD_IDLE;
            end
            default: state_d = GCD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GCD_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            gcd_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            gcd_q   <= gcd_d;
        end
    end

`ifdef GCD_CYCLES_EN
    logic [CW-1:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == GCD_IDLE && in_valid) begin
            cyc_d = '0;
        end else if ((state_q == GCD_EVEN || state_q == GCD_ODD) && cyc_q != '1) begin
            cyc_d = cyc_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign CYCLES = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_seq.sv
// ---------------------------------------------------------------------------
// tb_gcd_seq
//   Directed and random checks of gcd_seq at W=8 and W=16. Expected GCDs come
//   from a Euclid (modulo) reference model; latency is counted in rising
//   edges from the accept edge (inclusive) to the first edge after which
//   out_valid is high.
// ---------------------------------------------------------------------------
module tb_gcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v8, r8, ov8, or8;
    logic [7:0]  a8, b8, g8;
    logic        v16, r16, ov16, or16;
    logic [15:0] a16, b16, g16;
`ifdef GCD_CYCLES_EN
    logic [5:0]  cy8;
    logic [6:0]  cy16;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gcd_seq #(.W(8), .CW(6)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .A(a8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .GCD(g8)
`ifdef GCD_CYCLES_EN
        , .CYCLES(cy8)
`endif
    );

    gcd_seq #(.W(16), .CW(7)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .A(a16), .B(b16),
        .out_valid(ov16), .out_ready(or16), .GCD(g16)
`ifdef GCD_CYCLES_EN
        , .CYCLES(cy16)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic f_ov(input int w);
        return (w == 8) ? ov8 : ov16;
    endfunction

    function automatic logic f_rdy(input int w);
        return (w == 8) ? r8 : r16;
    endfunction

    function automatic logic [15:0] f_g(input int w);
        return (w == 8) ? {8'd0, g8} : g16;
    endfunction

    function automatic int f_cy(input int w);
`ifdef GCD_CYCLES_EN
        return (w == 8) ? int'(cy8) : int'(cy16);
`else
        return (w == 8) ? 0 : 0;
`endif
    endfunction

    // Present one operand pair, wait (bounded) for the result; leaves it unaccepted.
    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] g, output int lat, output int cyc);
        int t;
        t = 0;
        while (!f_rdy(w) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_before_op", 32'(f_rdy(w)), 32'd1);
        if (w == 8) begin v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
        else        begin v16 = 1'b1; a16 = a; b16 = b; end
        @(posedge clk);
        @(negedge clk);
        v8  = 1'b0;
        v16 = 1'b0;
        lat = 1;
        while (!f_ov(w) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        g   = f_g(w);
        cyc = f_cy(w);
    endtask

    task automatic release_res(input int w);
        if (w == 8) or8 = 1'b1; else or16 = 1'b1;
        @(negedge clk);
        or8  = 1'b0;
        or16 = 1'b0;
    endtask

    initial begin
        logic [15:0] g, ra, rb, mask;
        int lat, cyc, w;
        int ta[4] = '{48, 109, 127, 128};
        int tb[4] = '{12,  91, 127,  64};
        int te[4] = '{12,   1, 127,  64};
        int za[3] = '{0, 0, 35};
        int zb[3] = '{35, 0, 0};

        rst_n = 1'b0;
        v8 = 0; or8 = 0; a8 = 0; b8 = 0;
        v16 = 0; or16 = 0; a16 = 0; b16 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready8", 32'(r8), 32'd1);
        chk("rst_out_valid8", 32'(ov8), 32'd0);
        chk("rst_gcd8", 32'(g8), 32'd0);
        chk("rst_in_ready16", 32'(r16), 32'd1);
        chk("rst_out_valid16", 32'(ov16), 32'd0);
`ifdef GCD_CYCLES_EN
        chk("rst_cycles8", 32'(cy8), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 90/86 -> 2 within 34 cycles
        do_op(8, 16'd90, 16'd86, g, lat, cyc);
        chk("t1_gcd", 32'(g), 32'd2);
        chk("t1_lat_le34", 32'(lat <= 34), 32'd1);
`ifdef GCD_CYCLES_EN
        chk("t1_cycles_le34", 32'(cyc <= 34), 32'd1);
        chk("t1_cycles_eq", 32'(cyc), 32'(lat - 1));
`endif
        release_res(8);

        for (int i = 0; i < 4; i++) begin
            do_op(8, 16'(ta[i]), 16'(tb[i]), g, lat, cyc);
            chk("t2_gcd", 32'(g), 32'(te[i]));
            chk("t2_lat", 32'(lat <= 34), 32'd1);
            release_res(8);
        end

        // Zero operands go straight to DONE on the accept edge.
        for (int i = 0; i < 3; i++) begin
            do_op(8, 16'(za[i]), 16'(zb[i]), g, lat, cyc);
            chk("t3_gcd", 32'(g), 32'(za[i] | zb[i]));
            chk("t3_lat", 32'(lat), 32'd1);
`ifdef GCD_CYCLES_EN
            chk("t3_cycles", 32'(cyc), 32'd0);
`endif
            release_res(8);
        end

        // Back-pressure, then accept result and new operands together.
        do_op(8, 16'd54, 16'd44, g, lat, cyc);
        chk("t4_gcd", 32'(g), 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_gcd", 32'(g8), 32'd2);
            chk("t4_hold_ready", 32'(r8), 32'd0);
            chk("t4_hold_valid", 32'(ov8), 32'd1);
        end
        or8 = 1'b1; v8 = 1'b1; a8 = 8'd65; b8 = 8'd4;
        @(negedge clk);
        chk("t4_res_taken", 32'(ov8), 32'd0);
        chk("t4_idle_ready", 32'(r8), 32'd1);
        or8 = 1'b0;
        @(negedge clk);
        v8 = 1'b0;
        chk("t4_op2_taken", 32'(r8), 32'd0);
        lat = 1;
        while (!ov8 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("t4_gcd2", 32'(g8), 32'd1);
        chk("t4_lat2", 32'(lat <= 34), 32'd1);
        release_res(8);

        // Reset in the middle of an operation.
        v8 = 1'b1; a8 = 8'd95; b8 = 8'd32;
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy", 32'(r8), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(r8), 32'd1);
        chk("t5_rst_valid", 32'(ov8), 32'd0);
        chk("t5_rst_gcd", 32'(g8), 32'd0);
`ifdef GCD_CYCLES_EN
        chk("t5_rst_cycles", 32'(cy8), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_stale", 32'(ov8), 32'd0);
        end
        do_op(8, 16'd75, 16'd34, g, lat, cyc);
        chk("t5_gcd", 32'(g), 32'd1);
        release_res(8);

        // Random pairs against the Euclid model, both widths.
        for (int p = 0; p < 2; p++) begin
            w    = (p == 0) ? 8 : 16;
            mask = (p == 0) ? 16'h00ff : 16'hffff;
            for (int n = 0; n < 500; n++) begin
                ra = 16'($urandom) & mask;
                rb = 16'($urandom) & mask;
                if ($urandom_range(0, 15) == 0) ra = '0;
                if ($urandom_range(0, 15) == 0) rb = '0;
                do_op(w, ra, rb, g, lat, cyc);
                chk("rnd_gcd", 32'(g), 32'(ref_gcd(int'(ra), int'(rb))));
                chk("rnd_lat", 32'(lat <= 4 * w + 2), 32'd1);
`ifdef GCD_CYCLES_EN
                chk("rnd_cycles", 32'(cyc), 32'(lat - 1));
`endif
                release_res(w);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
